// File: rtl/line_buffer_scheduler.sv
// line_buffer_scheduler
//
// Sequencing controller for a four-line-buffer 3x3 convolution datapath.
// Incoming pixels are steered into a ring of four line buffers. Once three
// complete lines are resident, one-line read bursts are issued to the three
// oldest buffers, paced by downstream room. At end of frame the ring is
// flushed and a frame pulse is raised.
//
// Parameters:
//   LINE_WIDTH   pixels per line (>= 2)
//   FRAME_LINES  lines per input frame (>= 3)
// Ports:
//   i_clk         clock, all logic on rising edge
//   i_reset       asynchronous active-high reset
//   i_valid       upstream pixel valid
//   o_s_ready     upstream ready (pixel accepted on i_valid && o_s_ready)
//   i_out_ready   downstream can take one convolution result this cycle
//   o_wr_en       one-hot write enable to line buffers 0..3
//   o_wr_slct     index of the buffer being written
//   o_rd_en       read strobe to the active buffers / convolution valid
//   o_rd_slct     oldest active buffer; window is rd_slct, +1, +2 (mod 4)
//   o_line_intr   one-cycle pulse when an output line completes
//   o_frame_done  one-cycle pulse when the last output line of a frame completes
//   o_busy        high while reading/flushing or any line is resident

module line_buffer_scheduler #(
    parameter int LINE_WIDTH  = 512,
    parameter int FRAME_LINES = 512
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    output logic       o_s_ready,
    input  logic       i_out_ready,
    output logic [3:0] o_wr_en,
    output logic [1:0] o_wr_slct,
    output logic       o_rd_en,
    output logic [1:0] o_rd_slct,
    output logic       o_line_intr,
    output logic       o_frame_done,
    output logic       o_busy
);

    localparam int PIX_W = $clog2(LINE_WIDTH);
    localparam int IN_W  = $clog2(FRAME_LINES + 1);
    localparam int OUT_W = $clog2(FRAME_LINES - 1);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(LINE_WIDTH - 1);
    localparam logic [IN_W-1:0]  IN_FULL  = IN_W'(FRAME_LINES);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(FRAME_LINES - 3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [PIX_W-1:0] wr_pix;
    logic [1:0]       wr_slct;
    logic [IN_W-1:0]  in_lines;
    logic [2:0]       filled;
    logic [2:0]       filled_next;
    logic [PIX_W-1:0] rd_pix;
    logic [1:0]       rd_slct;
    logic [OUT_W-1:0] out_lines;

    logic accept;
    logic wr_line_done;
    logic rd_line_done;
    logic frame_end;
    logic retire;
    logic busy_next;

    // Write side: stall when the ring is full, the frame's input lines are
    // all in, or the ring is being flushed. Reset also forces ready low so
    // no write strobe escapes while reset is held.
    assign o_s_ready    = !i_reset && (filled != 3'd4) && (in_lines != IN_FULL)
                          && (state != FLUSH);
    assign accept       = i_valid && o_s_ready;
    assign o_wr_en      = accept ? (4'b0001 << wr_slct) : 4'b0000;
    assign wr_line_done = accept && (wr_pix == PIX_LAST);

    assign o_wr_slct = wr_slct;
    assign o_rd_slct = rd_slct;

    // Read FSM next state and read strobe. A read line completes on the
    // strobe at the last pixel; the final output line of the frame goes to
    // FLUSH instead of retiring its buffer.
    always_comb begin
        state_next = state;
        o_rd_en    = 1'b0;
        case (state)
            IDLE: begin
                if (filled >= 3'd3) begin
                    state_next = READ;
                end
            end
            READ: begin
                o_rd_en = i_out_ready;
                if (i_out_ready && (rd_pix == PIX_LAST)) begin
                    state_next = (out_lines == OUT_LAST) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_line_done = o_rd_en && (rd_pix == PIX_LAST);
    assign frame_end    = rd_line_done && (out_lines == OUT_LAST);
    assign retire       = rd_line_done && !frame_end;

    // Resident line count: a completed write and a retired read in the same
    // cycle cancel out.
    always_comb begin
        filled_next = filled;
        if (state == FLUSH) begin
            filled_next = 3'd0;
        end else if (wr_line_done && !retire) begin
            filled_next = filled + 3'd1;
        end else if (!wr_line_done && retire) begin
            filled_next = filled - 3'd1;
        end
    end

    assign busy_next = (state_next != IDLE) || (filled_next != 3'd0);

    // State, counters and registered pulses. The frame pulse is registered
    // from the last strobe so it lands in the single FLUSH cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            wr_pix       <= '0;
            wr_slct      <= 2'd0;
            in_lines     <= '0;
            filled       <= 3'd0;
            rd_pix       <= '0;
            rd_slct      <= 2'd0;
            out_lines    <= '0;
            o_line_intr  <= 1'b0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_next;
            filled       <= filled_next;
            o_busy       <= busy_next;
            o_line_intr  <= rd_line_done;
            o_frame_done <= frame_end;
            if (state == FLUSH) begin
                wr_pix    <= '0;
                wr_slct   <= 2'd0;
                in_lines  <= '0;
                rd_pix    <= '0;
                rd_slct   <= 2'd0;
                out_lines <= '0;
            end else begin
                if (accept) begin
                    if (wr_pix == PIX_LAST) begin
                        wr_pix   <= '0;
                        wr_slct  <= wr_slct + 2'd1;
                        in_lines <= in_lines + IN_W'(1);
                    end else begin
                        wr_pix <= wr_pix + PIX_W'(1);
                    end
                end
                if (o_rd_en) begin
                    if (rd_pix == PIX_LAST) begin
                        rd_pix    <= '0;
                        out_lines <= out_lines + OUT_W'(1);
                        if (!frame_end) begin
                            rd_slct <= rd_slct + 2'd1;
                        end
                    end else begin
                        rd_pix <= rd_pix + PIX_W'(1);
                    end
                end
            end
        end
    end

endmodule
